// File: rtl/gated_clk_en_ctrl.sv
// Clock-gating enable controller: gates local_en after an idle window, re-enables with a
// settle delay on wake, and runs a level sleep req/ack handshake that controls module_en.
module gated_clk_en_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic busy_in,
    input  logic wake_req,
    input  logic pmu_sleep_req,
    input  logic force_on,
    output logic local_en,
    output logic module_en,
    output logic pmu_sleep_ack,
    output logic wake_ready,
    output logic clk_gated
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_CNT   = 2'd1,
        S_GATED = 2'd2,
        S_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ack_q;
    logic             pend_q;
    logic             idle_s;
    logic             wake_ev_s;

    assign idle_s    = ~busy_in & ~wake_req;
    assign wake_ev_s = busy_in | wake_req | pend_q;

    // FSM, shared idle/wake counter, pending-wake flag and sleep acknowledge
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_RUN;
            cnt_q   <= CNT_ZERO;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (idle_s) begin
                        state_q <= S_CNT;
                        cnt_q   <= CNT_ZERO;
                    end
                end
                S_CNT: begin
                    if (!idle_s) begin
                        state_q <= S_RUN;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_q <= S_GATED;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_GATED: begin
                    // A wake can only leave GATED once the power manager has released the ack
                    if (wake_ev_s && !ack_q) begin
                        pend_q  <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                        state_q <= (WAKE_CYCLES == 0) ? S_RUN : S_WAKE;
                    end else if (ack_q && (busy_in || wake_req)) begin
                        pend_q <= 1'b1;
                    end
                end
                S_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_q <= S_RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= CNT_ZERO;
                end
            endcase

            // A granted ack is held until the request drops; a wake on the same edge wins over a new grant
            if (ack_q) begin
                if (!pmu_sleep_req) begin
                    ack_q <= 1'b0;
                end
            end else if (pmu_sleep_req && (state_q == S_GATED) && !force_on && !wake_ev_s) begin
                ack_q <= 1'b1;
            end
        end
    end

    assign local_en      = (state_q != S_GATED) | force_on;
    assign module_en     = ~ack_q | force_on;
    assign pmu_sleep_ack = ack_q;
    assign wake_ready    = (state_q == S_RUN) | (state_q == S_CNT);
    assign clk_gated     = (state_q == S_GATED);

endmodule

// File: tb/tb_gated_clk_en_ctrl.sv
// Directed plus randomized bench for gated_clk_en_ctrl, checked against an idle-streak /
// settle-countdown reference model.
module tb_gated_clk_en_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;

    logic clk_in = 1'b0;
    logic rst_in, busy_in, wake_req, pmu_sleep_req, force_on;
    logic local_en, module_en, pmu_sleep_ack, wake_ready, clk_gated;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: gated flag, edges of settle left, consecutive awake idle edges
    bit m_gated;
    int m_settle;
    int m_streak;
    bit m_ack;
    bit m_pend;

    gated_clk_en_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .busy_in(busy_in), .wake_req(wake_req),
        .pmu_sleep_req(pmu_sleep_req), .force_on(force_on), .local_en(local_en),
        .module_en(module_en), .pmu_sleep_ack(pmu_sleep_ack), .wake_ready(wake_ready),
        .clk_gated(clk_gated)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_gated = 1'b0; m_settle = 0; m_streak = 0; m_ack = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_edge(bit b, bit w, bit r, bit f);
        bit n_gated  = m_gated;
        int n_settle = m_settle;
        int n_streak = m_streak;
        bit n_pend   = m_pend;
        bit woke     = 1'b0;
        bit n_ack;
        if (m_gated) begin
            if ((b || w || m_pend) && !m_ack) begin
                woke = 1'b1; n_gated = 1'b0; n_settle = WAKE; n_pend = 1'b0; n_streak = 0;
            end else if (m_ack && (b || w)) begin
                n_pend = 1'b1;
            end
        end else if (m_settle > 0) begin
            n_settle = m_settle - 1;
            n_streak = 0;
        end else begin
            n_streak = (!b && !w) ? m_streak + 1 : 0;
            if (n_streak == IDLE + 1) begin
                n_gated = 1'b1; n_streak = 0;
            end
        end
        n_ack = m_ack ? r : (r && m_gated && !f && !woke);
        m_gated = n_gated; m_settle = n_settle; m_streak = n_streak; m_ack = n_ack; m_pend = n_pend;
    endtask

    task automatic cmp(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        cmp({tag, ".local_en"},  local_en,      !m_gated || force_on);
        cmp({tag, ".module_en"}, module_en,     !m_ack || force_on);
        cmp({tag, ".ack"},       pmu_sleep_ack, m_ack);
        cmp({tag, ".ready"},     wake_ready,    !m_gated && (m_settle == 0));
        cmp({tag, ".gated"},     clk_gated,     m_gated);
    endtask

    task automatic step(string tag);
        @(posedge clk_in);
        model_edge(busy_in, wake_req, pmu_sleep_req, force_on);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_in = 1'b1; busy_in = 1'b0; wake_req = 1'b0; pmu_sleep_req = 1'b0; force_on = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        cmp("reset.local_en_const", local_en, 1'b1);
        busy_in = 1'b1;
        rst_in  = 1'b0;

        for (int i = 0; i < 10; i++) step("busy");

        // idle window: gate after the fifth idle edge, then wake with settle
        busy_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step("idle");
            if (i == 4) cmp("idle.E4_local_en", local_en, 1'b1);
            if (i == 5) cmp("idle.E5_gated", clk_gated, 1'b1);
        end
        wake_req = 1'b1;
        step("wake_E9");
        cmp("wake.E9_local_en", local_en, 1'b1);
        cmp("wake.E9_ready", wake_ready, 1'b0);
        wake_req = 1'b0;
        step("wake_E10");
        step("wake_E11");
        cmp("wake.E11_ready", wake_ready, 1'b1);

        // busy on the fourth idle edge restarts the window
        for (int i = 0; i < 3; i++) step("short_idle");
        busy_in = 1'b1;
        step("short_busy");
        busy_in = 1'b0;
        for (int i = 0; i < 4; i++) step("restart_idle");
        cmp("restart.not_gated", clk_gated, 1'b0);
        step("restart_gate");
        cmp("restart.gated", clk_gated, 1'b1);

        // sleep handshake with a wake held pending while acked
        pmu_sleep_req = 1'b1;
        step("sleep_req");
        cmp("sleep.module_en", module_en, 1'b0);
        wake_req = 1'b1;
        step("wake_while_ack");
        wake_req = 1'b0;
        step("pend_hold");
        cmp("pend.still_gated", clk_gated, 1'b1);
        pmu_sleep_req = 1'b0;
        step("sleep_release");
        cmp("release.ack", pmu_sleep_ack, 1'b0);
        step("pend_wake");
        cmp("pend_wake.local_en", local_en, 1'b1);
        step("pend_settle");
        step("pend_ready");
        cmp("pend.ready", wake_ready, 1'b1);

        // force_on override while gated
        for (int i = 0; i < 5; i++) step("regate");
        force_on = 1'b1;
        #1;
        check_all("force_now");
        cmp("force.gated", clk_gated, 1'b1);
        pmu_sleep_req = 1'b1;
        for (int i = 0; i < 3; i++) step("force_blocks_ack");
        force_on = 1'b0;
        step("ack_after_force");
        force_on = 1'b1;
        step("force_over_ack");
        force_on = 1'b0;
        #1;
        check_all("ack_visible");

        // asynchronous reset while acked
        #2;
        rst_in = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        cmp("async_reset.module_en", module_en, 1'b1);
        #5;
        pmu_sleep_req = 1'b0;
        busy_in = 1'b1;
        rst_in = 1'b0;
        step("after_reset");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            busy_in  = ((i % 120) < 60) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            wake_req = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) pmu_sleep_req = ~pmu_sleep_req;
            force_on = ($urandom_range(0, 19) == 0);
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
